// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port synchronous memory: load/store has priority,
// a starvation counter guarantees instruction-fetch progress, read data is routed to its owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,

  input  logic                  ls_req_valid,
  input  logic                  ls_req_we,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_req_ready,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_data,

  input  logic [DATA_WIDTH-1:0] MEM_MEMCTRL_from_mem_data,
  output logic                  MEMCTRL_MEM_to_mem_read_enable,
  output logic                  MEMCTRL_MEM_to_mem_write_enable,
  output logic                  MEMCTRL_MEM_to_mem_mem_enable,
  output logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
  output logic [DATA_WIDTH-1:0] MEMCTRL_MEM_to_mem_data
);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnLs   = 2'd2
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  owner_e     rsp_owner_q, rsp_owner_d;
  logic       if_gnt, ls_gnt;

  // Reset gates the grant so no access or handshake can occur while it is held.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req_valid && ls_req_valid) begin
        if (starve_cnt_q == StarveMax) begin
          if_gnt = 1'b1;
        end else begin
          ls_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req_valid;
        ls_gnt = ls_req_valid;
      end
    end
  end

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;

  always_comb begin
    MEMCTRL_MEM_to_mem_read_enable  = 1'b0;
    MEMCTRL_MEM_to_mem_write_enable = 1'b0;
    MEMCTRL_MEM_to_mem_address      = '0;
    MEMCTRL_MEM_to_mem_data         = '0;
    if (if_gnt) begin
      MEMCTRL_MEM_to_mem_read_enable = 1'b1;
      MEMCTRL_MEM_to_mem_address     = if_req_addr;
    end else if (ls_gnt) begin
      MEMCTRL_MEM_to_mem_address = ls_req_addr;
      if (ls_req_we) begin
        MEMCTRL_MEM_to_mem_write_enable = 1'b1;
        MEMCTRL_MEM_to_mem_data         = ls_req_wdata;
      end else begin
        MEMCTRL_MEM_to_mem_read_enable = 1'b1;
      end
    end
  end

  assign MEMCTRL_MEM_to_mem_mem_enable =
      MEMCTRL_MEM_to_mem_read_enable | MEMCTRL_MEM_to_mem_write_enable;

  // Counts LS wins while IF waits; saturates so IF wins at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rsp_owner_d = OwnNone;
    if (if_gnt) begin
      rsp_owner_d = OwnIf;
    end else if (ls_gnt && !ls_req_we) begin
      rsp_owner_d = OwnLs;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rsp_owner_q  <= OwnNone;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  assign if_rsp_valid = (rsp_owner_q == OwnIf);
  assign ls_rsp_valid = (rsp_owner_q == OwnLs);
  assign if_rsp_data  = if_rsp_valid ? MEM_MEMCTRL_from_mem_data : '0;
  assign ls_rsp_data  = ls_rsp_valid ? MEM_MEMCTRL_from_mem_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: synchronous memory model, constant vector table, corner
// sequences and random traffic checked against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int StarveLimit = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [11:0] if_req_addr;
  logic [15:0] if_rsp_data;
  logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
  logic [11:0] ls_req_addr;
  logic [15:0] ls_req_wdata, ls_rsp_data;
  logic [15:0] mem_dout;
  logic        mem_re, mem_we, mem_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;

  mem_port_arbiter #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (16),
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .if_req_valid                   (if_req_valid),
    .if_req_addr                    (if_req_addr),
    .if_req_ready                   (if_req_ready),
    .if_rsp_valid                   (if_rsp_valid),
    .if_rsp_data                    (if_rsp_data),
    .ls_req_valid                   (ls_req_valid),
    .ls_req_we                      (ls_req_we),
    .ls_req_addr                    (ls_req_addr),
    .ls_req_wdata                   (ls_req_wdata),
    .ls_req_ready                   (ls_req_ready),
    .ls_rsp_valid                   (ls_rsp_valid),
    .ls_rsp_data                    (ls_rsp_data),
    .MEM_MEMCTRL_from_mem_data      (mem_dout),
    .MEMCTRL_MEM_to_mem_read_enable (mem_re),
    .MEMCTRL_MEM_to_mem_write_enable(mem_we),
    .MEMCTRL_MEM_to_mem_mem_enable  (mem_en),
    .MEMCTRL_MEM_to_mem_address     (mem_addr),
    .MEMCTRL_MEM_to_mem_data        (mem_din)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input int i);
    case (i)
      'h010:   return 16'hABCD;
      'h030:   return 16'h5A5A;
      'hFFF:   return 16'hBEEF;
      default: return 16'(i * 37 + 5);
    endcase
  endfunction

  // Synchronous single-port memory: one process owns the array.
  logic [15:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    mem_dout = '0;
    forever begin
      @(posedge clock);
      if (mem_we) mem[mem_addr] <= mem_din;
      else if (mem_re) mem_dout <= mem[mem_addr];
    end
  end

  // Reference: shadow memory plus a queue of outstanding read responses.
  typedef struct packed {
    logic        is_if;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] ref_mem [4096];
  rsp_t        rq[$];
  int          ref_wait;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        s_if_rdy, s_ls_rdy, s_if_rsp, s_ls_rsp;
  logic [15:0] s_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic iv, input logic [11:0] ia, input logic lv,
                       input logic lwe, input logic [11:0] la, input logic [15:0] lwd);
    logic g_if, g_ls, e_iv, e_lv;
    logic [15:0] e_rd;
    rsp_t r;
    if_req_valid = iv;
    if_req_addr  = ia;
    ls_req_valid = lv;
    ls_req_we    = lwe;
    ls_req_addr  = la;
    ls_req_wdata = lwd;
    g_if = iv && (!lv || ref_wait == StarveLimit);
    g_ls = lv && !g_if;
    e_iv = 1'b0;
    e_lv = 1'b0;
    e_rd = '0;
    if (rq.size() > 0) begin
      r = rq.pop_front();
      e_iv = r.is_if;
      e_lv = !r.is_if;
      e_rd = r.data;
    end
    @(negedge clock);
    s_if_rdy = if_req_ready;
    s_ls_rdy = ls_req_ready;
    s_if_rsp = if_rsp_valid;
    s_ls_rsp = ls_rsp_valid;
    s_rdata  = if_rsp_valid ? if_rsp_data : ls_rsp_data;
    chk("if_req_ready", 32'(if_req_ready), 32'(g_if));
    chk("ls_req_ready", 32'(ls_req_ready), 32'(g_ls));
    chk("read_enable", 32'(mem_re), 32'(g_if || (g_ls && !lwe)));
    chk("write_enable", 32'(mem_we), 32'(g_ls && lwe));
    chk("mem_enable", 32'(mem_en), 32'(g_if || g_ls));
    chk("mem_address", 32'(mem_addr), 32'(g_if ? ia : (g_ls ? la : 12'h0)));
    chk("mem_data", 32'(mem_din), 32'((g_ls && lwe) ? lwd : 16'h0));
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_iv));
    chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(e_lv));
    chk("if_rsp_data", 32'(if_rsp_data), 32'(e_iv ? e_rd : 16'h0));
    chk("ls_rsp_data", 32'(ls_rsp_data), 32'(e_lv ? e_rd : 16'h0));
    if (g_if) begin
      r.is_if = 1'b1;
      r.data  = ref_mem[ia];
      rq.push_back(r);
    end else if (g_ls && !lwe) begin
      r.is_if = 1'b0;
      r.data  = ref_mem[la];
      rq.push_back(r);
    end else if (g_ls) begin
      ref_mem[la] = lwd;
    end
    if (!iv || g_if) ref_wait = 0;
    else if (g_ls && ref_wait < StarveLimit) ref_wait++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 16'h0);
  endtask

  // Asynchronous reset asserted mid-cycle with both requesters still asking.
  task automatic mid_reset();
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
    chk("rst_ls_rsp_valid", 32'(ls_rsp_valid), 32'h0);
    chk("rst_readys", 32'({if_req_ready, ls_req_ready}), 32'h0);
    chk("rst_enables", 32'({mem_re, mem_we, mem_en}), 32'h0);
    chk("rst_address", 32'(mem_addr), 32'h0);
    chk("rst_mem_data", 32'(mem_din), 32'h0);
    chk("rst_starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
    @(negedge clock);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1 reset = 1'b0;
    rq.delete();
    ref_wait = 0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [11:0] ia;
    logic        lv;
    logic        lwe;
    logic [11:0] la;
    logic [15:0] lwd;
    logic        e_irdy;
    logic        e_lrdy;
    logic [11:0] e_addr;
    logic [15:0] e_data;
    logic        e_irsp;
    logic        e_lrsp;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t        vecs[8];
  logic        p_iv, p_lv, p_lwe;
  logic [11:0] p_ia, p_la;
  logic [15:0] p_lwd;

  initial begin
    vecs[0] = '{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h010, 16'h0000,
                1'b1, 1'b0, 16'hABCD};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 16'h1234, 1'b0, 1'b1, 12'h020, 16'h1234,
                1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b1, 12'h020, 16'h0000,
                1'b0, 1'b1, 16'h1234};
    vecs[3] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h030, 16'h0000, 1'b0, 1'b1, 12'h030, 16'h0000,
                1'b0, 1'b1, 16'h5A5A};
    vecs[4] = '{1'b0, 12'h123, 1'b0, 1'b1, 12'h456, 16'h7777, 1'b0, 1'b0, 12'h000, 16'h0000,
                1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000,
                1'b1, 1'b0, 16'hBEEF};
    vecs[6] = '{1'b1, 12'h010, 1'b1, 1'b1, 12'hFFF, 16'h0001, 1'b0, 1'b1, 12'hFFF, 16'h0001,
                1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, 1'b1, 12'hFFF, 16'h0000,
                1'b0, 1'b1, 16'h0001};

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    ref_wait     = 0;
    reset        = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 12'h010;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 12'h020;
    ls_req_wdata = 16'hFFFF;
    #12;
    chk("init_readys", 32'({if_req_ready, ls_req_ready}), 32'h0);
    chk("init_enables", 32'({mem_re, mem_we, mem_en}), 32'h0);
    chk("init_address", 32'(mem_addr), 32'h0);
    chk("init_rsp_valid", 32'({if_rsp_valid, ls_rsp_valid}), 32'h0);
    chk("init_starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Constant vectors, each followed by an idle cycle that carries its response.
    for (int v = 0; v < 8; v++) begin
      cycle(vecs[v].iv, vecs[v].ia, vecs[v].lv, vecs[v].lwe, vecs[v].la, vecs[v].lwd);
      chk($sformatf("vec%0d_if_ready", v), 32'(s_if_rdy), 32'(vecs[v].e_irdy));
      chk($sformatf("vec%0d_ls_ready", v), 32'(s_ls_rdy), 32'(vecs[v].e_lrdy));
      idle();
      chk($sformatf("vec%0d_if_rsp", v), 32'(s_if_rsp), 32'(vecs[v].e_irsp));
      chk($sformatf("vec%0d_ls_rsp", v), 32'(s_ls_rsp), 32'(vecs[v].e_lrsp));
      chk($sformatf("vec%0d_rsp_data", v), 32'(s_rdata), 32'(vecs[v].e_rdata));
    end

    // Write followed immediately by a read of the same word.
    cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h4321);
    cycle(1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 16'h0);
    idle();
    chk("raw_ls_rsp", 32'(s_ls_rsp), 32'h1);
    chk("raw_data", 32'(s_rdata), 32'h4321);

    // Continuous contention: LS,LS,LS,LS,IF repeating.
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 12'h010, 1'b1, 1'b0, 12'(i), 16'h0);
      chk("starve_pattern", 32'(s_if_rdy), 32'((i % 5) == 4));
    end
    idle();

    // Alternating single requesters, one access per cycle.
    for (int i = 0; i < 10; i++) begin
      if ((i % 2) == 0) cycle(1'b1, 12'h000, 1'b0, 1'b0, 12'h0, 16'h0);
      else cycle(1'b0, 12'h0, 1'b1, 1'b0, 12'h001, 16'h0);
      chk("alt_no_bubble", 32'(s_if_rdy || s_ls_rdy), 32'h1);
      if (i > 0) chk("alt_owner", 32'(s_if_rsp), 32'((i % 2) == 1));
    end

    // Reset the cycle after an IF read handshake.
    cycle(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 16'h0);
    mid_reset();
    for (int i = 0; i < 3; i++) idle();

    // Reset while the starvation counter is part-way up.
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'h030, 1'b1, 1'b0, 12'h040, 16'h0);
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 12'h030, 1'b1, 1'b0, 12'h040, 16'h0);
      chk("post_rst_starve", 32'(s_if_rdy), 32'(i == 4));
    end

    for (int i = 0; i < 10; i++) begin
      idle();
      chk("idle_mem_enable", 32'(mem_en), 32'h0);
    end

    // Random traffic; a stalled request is held stable until accepted.
    p_iv = 1'b0;
    p_lv = 1'b0;
    p_ia = '0;
    p_la = '0;
    p_lwe = 1'b0;
    p_lwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(p_iv && !s_if_rdy)) begin
        p_iv = ($urandom_range(0, 3) != 0);
        p_ia = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      end
      if (!(p_lv && !s_ls_rdy)) begin
        p_lv  = ($urandom_range(0, 3) != 0);
        p_lwe = ($urandom_range(0, 2) == 0);
        p_la  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
        p_lwd = 16'($urandom);
      end
      cycle(p_iv, p_ia, p_lv, p_lwe, p_la, p_lwd);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 4096x16 synchronous `memory` between two requesters inside `cpu`: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Arbitrates per cycle and drives the `MEMCTRL_MEM_to_mem_*` pins.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- LS has priority; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_WIDTH, 12, word address width (4096 words).
- DATA_WIDTH, 16, memory word width.
- STARVE_LIMIT, 4, max consecutive LS grants while IF is waiting; range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_addr  in  ADDR_WIDTH  IF word address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_rsp_valid  out  1  IF read data valid.
- if_rsp_data  out  DATA_WIDTH  IF read data.
- ls_req_valid  in  1  LS request.
- ls_req_we  in  1  1 = write, 0 = read.
- ls_req_addr  in  ADDR_WIDTH  LS word address.
- ls_req_wdata  in  DATA_WIDTH  LS write data.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_rsp_valid  out  1  LS read data valid (reads only).
- ls_rsp_data  out  DATA_WIDTH  LS read data.
- MEM_MEMCTRL_from_mem_data  in  DATA_WIDTH  memory dout.
- MEMCTRL_MEM_to_mem_read_enable  out  1  memory read strobe.
- MEMCTRL_MEM_to_mem_write_enable  out  1  memory write strobe.
- MEMCTRL_MEM_to_mem_mem_enable  out  1  high whenever any access is issued.
- MEMCTRL_MEM_to_mem_address  out  ADDR_WIDTH  memory address.
- MEMCTRL_MEM_to_mem_data  out  DATA_WIDTH  memory write data.

Behaviour:
- Clocking and reset: one clock domain on `clock`. `reset` is asynchronous and active-high.
- While `reset` is high:
  - starve_cnt = 0, rsp_owner = NONE.
  - if/ls_rsp_valid = 0.
  - Both readys = 0.
  - All memory enables = 0, address = 0, memory data = 0.
- Memory model: address, enables and din are sampled at rising edge N. Read dout is valid during cycle N+1.
- Grant (combinational each cycle, from valids and starve_cnt):
  - Only LS valid -> LS.
  - Only IF valid -> IF.
  - Both valid -> IF if starve_cnt == STARVE_LIMIT, else LS.
  - Neither -> idle.
- Granted requester sees req_ready = 1; the other sees 0. The handshake completes when valid and ready are high at the same edge.
- Requester contract: must hold addr/we/wdata stable while valid is high and ready is low.
- Memory pins:
  - IF grant: read_en = 1, write_en = 0, address = if_req_addr, data = 0.
  - LS read: read_en = 1, write_en = 0, address = ls_req_addr, data = 0.
  - LS write: read_en = 0, write_en = 1, address = ls_req_addr, data = ls_req_wdata.
  - mem_enable = read_en | write_en.
  - Idle: all enables 0, address 0, data 0.
- Response tracking: rsp_owner register holds one of NONE, IF, LS.
  - Loaded at each edge: IF if an IF read was granted, LS if an LS read was granted, else NONE.
  - LS writes load NONE and produce no response.
- Response outputs:
  - if_rsp_valid = (rsp_owner == IF); ls_rsp_valid = (rsp_owner == LS).
  - Both rsp_data outputs = MEM_MEMCTRL_from_mem_data when their valid is high, else 0.
- Latency and throughput: exactly 1 cycle from handshake to response. Back-to-back accesses are allowed, 1 access per cycle, no bubbles. Responses have no backpressure.
- Starvation counter (starve_cnt, 4 bit):
  - Increments when LS is granted while if_req_valid = 1.
  - Cleared when IF is granted, or when if_req_valid = 0.
  - Saturates at STARVE_LIMIT.
- Simultaneous events:
  - A new request and a response for the previous request occur in the same cycle and are independent.
  - An LS write followed by an LS read of the same address on the next cycle returns the new data (memory write-first, sequential edges).
- Reset mid-operation: an in-flight read response is discarded. No rsp_valid is issued after reset deasserts until a new handshake.
- Address is passed straight through; there is no wrap or overflow logic.

Test Plan:
- Preload word 0x010 = 0xABCD; IF reads 0x010 alone -> if_req_ready = 1 in cycle N; in N+1 if_rsp_valid = 1 and if_rsp_data = 0xABCD; ls_rsp_valid stays 0.
- LS write 0x020 <- 0x1234 in cycle N, then LS read 0x020 in N+1 -> write_en = 1 in N with no response; ls_rsp_data = 0x1234 in N+2.
- IF and LS both request continuously with STARVE_LIMIT = 4 -> grant pattern LS,LS,LS,LS,IF repeating; IF is never blocked for more than 4 cycles.
- Alternating IF read 0x000 and LS read 0x001, every cycle -> responses return in issue order with correct owner and data; zero bubbles.
- Assert reset one cycle after an IF read handshake -> if_rsp_valid stays 0; all memory enables go 0 immediately (asynchronous); starve_cnt = 0.
- No requests for 10 cycles -> mem_enable = 0, address = 0, both rsp_valid = 0 throughout.
